// File: rtl/pe_pkg.sv
// Shared types and constants for the PE load sequencer: FSM state encoding,
// GLB stream select codes, default PE config field widths and phase ordering.
package pe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CFG    = 3'd1,
    ST_FILTER = 3'd2,
    ST_IFMAP  = 3'd3,
    ST_IPSUM  = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } pe_state_e;

  localparam logic [1:0] SRC_SEL_FILTER = 2'd0;
  localparam logic [1:0] SRC_SEL_IFMAP  = 2'd1;
  localparam logic [1:0] SRC_SEL_IPSUM  = 2'd2;
  localparam logic [1:0] SRC_SEL_NONE   = 2'd3;

  localparam int DEF_CONFIG_Q_BIT = 2;
  localparam int DEF_CONFIG_P_BIT = 5;
  localparam int DEF_CONFIG_U_BIT = 4;
  localparam int DEF_CONFIG_S_BIT = 4;
  localparam int DEF_CONFIG_F_BIT = 12;
  localparam int DEF_CONFIG_W_BIT = 12;

  // First stream phase after cur whose beat count is nonzero; DRAIN when none remain.
  function automatic pe_state_e next_phase(input pe_state_e cur, input logic nz_f,
                                           input logic nz_i, input logic nz_p);
    next_phase = ST_DRAIN;
    if (cur == ST_CFG && nz_f)
      next_phase = ST_FILTER;
    else if ((cur == ST_CFG || cur == ST_FILTER) && nz_i)
      next_phase = ST_IFMAP;
    else if (cur != ST_IPSUM && nz_p)
      next_phase = ST_IPSUM;
  endfunction

endpackage

// File: rtl/pe_beat_counter.sv
// Saturating beat counter with compare-equal flags: last when one beat remains
// before the limit, full when the limit has been reached.
module pe_beat_counter #(
  parameter int CNT_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_inc,
  input  logic [CNT_BIT-1:0] i_limit,
  output logic [CNT_BIT-1:0] o_count,
  output logic               o_last,
  output logic               o_full
);

  localparam logic [CNT_BIT-1:0] ONE = {{(CNT_BIT-1){1'b0}}, 1'b1};

  logic [CNT_BIT-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_count <= '0;
    else if (i_clear)
      r_count <= '0;
    else if (i_inc && !o_full)
      r_count <= r_count + ONE;
  end

  assign o_count = r_count;
  assign o_full  = (r_count == i_limit);
  assign o_last  = (r_count == (i_limit - ONE));

endmodule

// File: rtl/pe_load_sequencer.sv
// Per-PE load controller: programs the PE config, streams filter/ifmap/ipsum beats
// from the shared GLB read stream into the PE, and forwards PE opsum beats to the GLB.
module pe_load_sequencer
  import pe_pkg::*;
#(
  parameter int DATA_SIZE    = 8,
  parameter int FILTER_NUM   = 4,
  parameter int CNT_BIT      = 16,
  parameter int CONFIG_Q_BIT = DEF_CONFIG_Q_BIT,
  parameter int CONFIG_P_BIT = DEF_CONFIG_P_BIT,
  parameter int CONFIG_U_BIT = DEF_CONFIG_U_BIT,
  parameter int CONFIG_S_BIT = DEF_CONFIG_S_BIT,
  parameter int CONFIG_F_BIT = DEF_CONFIG_F_BIT,
  parameter int CONFIG_W_BIT = DEF_CONFIG_W_BIT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [CONFIG_Q_BIT-1:0]         cfg_q,
  input  logic [CONFIG_P_BIT-1:0]         cfg_p,
  input  logic [CONFIG_U_BIT-1:0]         cfg_U,
  input  logic [CONFIG_S_BIT-1:0]         cfg_S,
  input  logic [CONFIG_F_BIT-1:0]         cfg_F,
  input  logic [CONFIG_W_BIT-1:0]         cfg_W,
  input  logic [CNT_BIT-1:0]              n_filter,
  input  logic [CNT_BIT-1:0]              n_ifmap,
  input  logic [CNT_BIT-1:0]              n_ipsum,
  input  logic [CNT_BIT-1:0]              n_opsum,
  output logic                            busy,
  output logic                            done,
  output logic [1:0]                      src_sel,
  input  logic                            src_valid,
  input  logic [FILTER_NUM*DATA_SIZE-1:0] src_data,
  output logic                            src_ready,
  output logic                            snk_valid,
  output logic [DATA_SIZE-1:0]            snk_data,
  input  logic                            snk_ready,
  output logic                            set_info,
  output logic [CONFIG_Q_BIT-1:0]         config_q,
  output logic [CONFIG_P_BIT-1:0]         config_p,
  output logic [CONFIG_U_BIT-1:0]         config_U,
  output logic [CONFIG_S_BIT-1:0]         config_S,
  output logic [CONFIG_F_BIT-1:0]         config_F,
  output logic [CONFIG_W_BIT-1:0]         config_W,
  output logic [FILTER_NUM*DATA_SIZE-1:0] filter,
  output logic                            filter_enable,
  input  logic                            filter_ready,
  output logic [DATA_SIZE-1:0]            ifmap,
  output logic                            ifmap_enable,
  input  logic                            ifmap_ready,
  output logic [DATA_SIZE-1:0]            ipsum,
  output logic                            ipsum_enable,
  input  logic                            ipsum_ready,
  input  logic [DATA_SIZE-1:0]            opsum,
  input  logic                            opsum_enable,
  output logic                            opsum_ready,
  output pe_state_e                       dbg_state,
  output logic [CNT_BIT-1:0]              dbg_in_count,
  output logic [CNT_BIT-1:0]              dbg_op_count,
  output logic [1:0]                      dbg_flags
);

  // Handshake: every stream moves one beat on a posedge where valid and ready are
  // both high; this block only steers valid/ready through, it never buffers data.

  pe_state_e r_state, w_next;

  logic [CONFIG_Q_BIT-1:0] r_cfg_q;
  logic [CONFIG_P_BIT-1:0] r_cfg_p;
  logic [CONFIG_U_BIT-1:0] r_cfg_U;
  logic [CONFIG_S_BIT-1:0] r_cfg_S;
  logic [CONFIG_F_BIT-1:0] r_cfg_F;
  logic [CONFIG_W_BIT-1:0] r_cfg_W;
  logic [CNT_BIT-1:0]      r_n_filter, r_n_ifmap, r_n_ipsum, r_n_opsum;

  logic               w_nz_f, w_nz_i, w_nz_p;
  logic               w_stream, w_active;
  logic               w_in_beat, w_in_last, w_in_full, w_in_clear;
  logic [CNT_BIT-1:0] w_in_limit, w_in_count;
  logic               w_op_beat, w_op_last, w_op_full, w_op_clear;
  logic [CNT_BIT-1:0] w_op_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cfg_q    <= '0;
      r_cfg_p    <= '0;
      r_cfg_U    <= '0;
      r_cfg_S    <= '0;
      r_cfg_F    <= '0;
      r_cfg_W    <= '0;
      r_n_filter <= '0;
      r_n_ifmap  <= '0;
      r_n_ipsum  <= '0;
      r_n_opsum  <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_cfg_q    <= cfg_q;
      r_cfg_p    <= cfg_p;
      r_cfg_U    <= cfg_U;
      r_cfg_S    <= cfg_S;
      r_cfg_F    <= cfg_F;
      r_cfg_W    <= cfg_W;
      r_n_filter <= n_filter;
      r_n_ifmap  <= n_ifmap;
      r_n_ipsum  <= n_ipsum;
      r_n_opsum  <= n_opsum;
    end
  end

  assign w_nz_f   = |r_n_filter;
  assign w_nz_i   = |r_n_ifmap;
  assign w_nz_p   = |r_n_ipsum;
  assign w_stream = (r_state == ST_FILTER) || (r_state == ST_IFMAP) || (r_state == ST_IPSUM);
  assign w_active = (r_state != ST_IDLE) && (r_state != ST_DONE);

  always_comb begin
    w_in_limit = '0;
    case (r_state)
      ST_FILTER: w_in_limit = r_n_filter;
      ST_IFMAP:  w_in_limit = r_n_ifmap;
      ST_IPSUM:  w_in_limit = r_n_ipsum;
      default:   w_in_limit = '0;
    endcase
  end

  always_comb begin
    w_next        = r_state;
    src_sel       = SRC_SEL_NONE;
    src_ready     = 1'b0;
    filter        = '0;
    filter_enable = 1'b0;
    ifmap         = '0;
    ifmap_enable  = 1'b0;
    ipsum         = '0;
    ipsum_enable  = 1'b0;
    w_in_beat     = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_CFG;
      ST_CFG:  w_next = next_phase(ST_CFG, w_nz_f, w_nz_i, w_nz_p);
      ST_FILTER: begin
        src_sel       = SRC_SEL_FILTER;
        filter        = src_data;
        filter_enable = src_valid;
        src_ready     = filter_ready;
        w_in_beat     = src_valid & filter_ready;
        if (w_in_beat && w_in_last) w_next = next_phase(ST_FILTER, w_nz_f, w_nz_i, w_nz_p);
      end
      ST_IFMAP: begin
        src_sel      = SRC_SEL_IFMAP;
        ifmap        = src_data[DATA_SIZE-1:0];
        ifmap_enable = src_valid;
        src_ready    = ifmap_ready;
        w_in_beat    = src_valid & ifmap_ready;
        if (w_in_beat && w_in_last) w_next = next_phase(ST_IFMAP, w_nz_f, w_nz_i, w_nz_p);
      end
      ST_IPSUM: begin
        src_sel      = SRC_SEL_IPSUM;
        ipsum        = src_data[DATA_SIZE-1:0];
        ipsum_enable = src_valid;
        src_ready    = ipsum_ready;
        w_in_beat    = src_valid & ipsum_ready;
        if (w_in_beat && w_in_last) w_next = ST_DRAIN;
      end
      ST_DRAIN: if (w_op_full) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // The phase counter restarts at the end of every phase so each phase counts from 0.
  assign w_in_clear = !w_stream || (w_in_beat && w_in_last);

  pe_beat_counter #(.CNT_BIT(CNT_BIT)) u_in_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_in_clear),
    .i_inc   (w_in_beat),
    .i_limit (w_in_limit),
    .o_count (w_in_count),
    .o_last  (w_in_last),
    .o_full  (w_in_full)
  );

  // Opsum beats are accepted from CFG through DRAIN until n_opsum have been taken.
  assign snk_valid   = w_active & opsum_enable & ~w_op_full;
  assign opsum_ready = w_active & snk_ready & ~w_op_full;
  assign snk_data    = w_active ? opsum : '0;
  assign w_op_beat   = opsum_enable & opsum_ready;
  assign w_op_clear  = (r_state == ST_IDLE);

  pe_beat_counter #(.CNT_BIT(CNT_BIT)) u_op_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_op_clear),
    .i_inc   (w_op_beat),
    .i_limit (r_n_opsum),
    .o_count (w_op_count),
    .o_last  (w_op_last),
    .o_full  (w_op_full)
  );

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign set_info = (r_state == ST_CFG);
  assign config_q = r_cfg_q;
  assign config_p = r_cfg_p;
  assign config_U = r_cfg_U;
  assign config_S = r_cfg_S;
  assign config_F = r_cfg_F;
  assign config_W = r_cfg_W;

  assign dbg_state    = r_state;
  assign dbg_in_count = w_in_count;
  assign dbg_op_count = w_op_count;
  assign dbg_flags    = {w_in_full, w_op_last};

endmodule

// File: tb/tb_pe_load_sequencer.sv
// Scoreboard bench for pe_load_sequencer: a GLB/PE driver process, a monitor that
// pops expected beats as the DUT presents them, and directed job scenarios.
module tb_pe_load_sequencer;
  import pe_pkg::*;

  localparam int DW = 8;
  localparam int FN = 4;
  localparam int CB = 16;
  localparam int SW = FN * DW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [1:0]  cfg_q = '0;
  logic [4:0]  cfg_p = '0;
  logic [3:0]  cfg_U = '0, cfg_S = '0;
  logic [11:0] cfg_F = '0, cfg_W = '0;
  logic [CB-1:0] n_filter = '0, n_ifmap = '0, n_ipsum = '0, n_opsum = '0;
  logic busy, done, src_ready, snk_valid, set_info;
  logic [1:0] src_sel;
  logic src_valid, snk_ready;
  logic [SW-1:0] src_data, filter;
  logic [DW-1:0] snk_data, ifmap, ipsum, opsum;
  logic [1:0]  config_q;
  logic [4:0]  config_p;
  logic [3:0]  config_U, config_S;
  logic [11:0] config_F, config_W;
  logic filter_enable, filter_ready, ifmap_enable, ifmap_ready, ipsum_enable, ipsum_ready;
  logic opsum_enable, opsum_ready;
  pe_state_e dbg_state;
  logic [CB-1:0] dbg_in_count, dbg_op_count;
  logic [1:0] dbg_flags;

  pe_load_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_q(cfg_q), .cfg_p(cfg_p), .cfg_U(cfg_U), .cfg_S(cfg_S), .cfg_F(cfg_F), .cfg_W(cfg_W),
    .n_filter(n_filter), .n_ifmap(n_ifmap), .n_ipsum(n_ipsum), .n_opsum(n_opsum),
    .busy(busy), .done(done), .src_sel(src_sel),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
    .set_info(set_info), .config_q(config_q), .config_p(config_p), .config_U(config_U),
    .config_S(config_S), .config_F(config_F), .config_W(config_W),
    .filter(filter), .filter_enable(filter_enable), .filter_ready(filter_ready),
    .ifmap(ifmap), .ifmap_enable(ifmap_enable), .ifmap_ready(ifmap_ready),
    .ipsum(ipsum), .ipsum_enable(ipsum_enable), .ipsum_ready(ipsum_ready),
    .opsum(opsum), .opsum_enable(opsum_enable), .opsum_ready(opsum_ready),
    .dbg_state(dbg_state), .dbg_in_count(dbg_in_count), .dbg_op_count(dbg_op_count),
    .dbg_flags(dbg_flags)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [SW-1:0] exp_f_q[$];
  logic [DW-1:0] exp_i_q[$], exp_p_q[$], exp_s_q[$];
  logic [SW-1:0] src_f[$], src_i[$], src_p[$];
  logic [DW-1:0] op_l[$];
  logic [38:0]   exp_cfg;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int unsigned stall_pct = 0;
  int op_mode = 0;
  int set_cnt, done_cnt, drain_cnt, fen_cnt, pen_cnt, fbeat_cnt;
  int last_src, last_snk, done_cyc, seq;
  pe_state_e last_state = ST_IDLE;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_note(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: actual=%0h required=nothing", name, act);
  endtask

  function automatic logic roll();
    return $urandom_range(0, 99) >= stall_pct;
  endfunction

  function automatic int exp_seq(input int nf, input int ni, input int np);
    int s;
    s = int'(ST_CFG);
    if (nf != 0) s = (s << 3) | int'(ST_FILTER);
    if (ni != 0) s = (s << 3) | int'(ST_IFMAP);
    if (np != 0) s = (s << 3) | int'(ST_IPSUM);
    s = (s << 3) | int'(ST_DRAIN);
    s = (s << 3) | int'(ST_DONE);
    return s;
  endfunction

  // ---------------- GLB / PE driver ----------------
  logic d_sb, d_ob;
  logic [1:0] d_ss;
  int d_rem;
  initial begin
    src_valid = 1'b0; src_data = '0; snk_ready = 1'b0; opsum_enable = 1'b0; opsum = '0;
    filter_ready = 1'b0; ifmap_ready = 1'b0; ipsum_ready = 1'b0;
    forever begin
      @(negedge clk);
      d_sb = src_valid && src_ready;
      d_ss = src_sel;
      d_ob = opsum_enable && opsum_ready;
      @(posedge clk);
      #1;
      if (d_sb) begin
        case (d_ss)
          SRC_SEL_FILTER: if (src_f.size() > 0) void'(src_f.pop_front());
          SRC_SEL_IFMAP:  if (src_i.size() > 0) void'(src_i.pop_front());
          SRC_SEL_IPSUM:  if (src_p.size() > 0) void'(src_p.pop_front());
          default: ;
        endcase
      end
      if (d_ob && op_l.size() > 0) void'(op_l.pop_front());
      src_valid = 1'b0;
      src_data  = '0;
      case (src_sel)
        SRC_SEL_FILTER: if (src_f.size() > 0) begin src_valid = roll(); src_data = src_f[0]; end
        SRC_SEL_IFMAP:  if (src_i.size() > 0) begin src_valid = roll(); src_data = src_i[0]; end
        SRC_SEL_IPSUM:  if (src_p.size() > 0) begin src_valid = roll(); src_data = src_p[0]; end
        default: ;
      endcase
      filter_ready = roll();
      ifmap_ready  = roll();
      ipsum_ready  = roll();
      snk_ready    = roll();
      opsum_enable = 1'b0;
      opsum        = '0;
      d_rem = src_f.size() + src_i.size() + src_p.size();
      if (op_l.size() > 0) begin
        opsum = op_l[0];
        case (op_mode)
          0:       opsum_enable = roll();
          1:       opsum_enable = (d_rem == 0) && roll();
          default: opsum_enable = (op_l.size() > 1) || (src_valid && d_rem == 1);
        endcase
      end
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      last_state = ST_IDLE;
    end else begin
      if (filter_enable) fen_cnt++;
      if (ipsum_enable) pen_cnt++;
      if (filter_enable && filter_ready) begin
        fbeat_cnt++;
        last_src = cyc;
        check("filter_sel", 64'(src_sel), 64'(SRC_SEL_FILTER));
        if (exp_f_q.size() == 0) fail_note("filter_extra", 64'(filter));
        else check("filter_data", 64'(filter), 64'(exp_f_q.pop_front()));
      end
      if (ifmap_enable && ifmap_ready) begin
        last_src = cyc;
        check("ifmap_sel", 64'(src_sel), 64'(SRC_SEL_IFMAP));
        if (exp_i_q.size() == 0) fail_note("ifmap_extra", 64'(ifmap));
        else check("ifmap_data", 64'(ifmap), 64'(exp_i_q.pop_front()));
      end
      if (ipsum_enable && ipsum_ready) begin
        last_src = cyc;
        check("ipsum_sel", 64'(src_sel), 64'(SRC_SEL_IPSUM));
        if (exp_p_q.size() == 0) fail_note("ipsum_extra", 64'(ipsum));
        else check("ipsum_data", 64'(ipsum), 64'(exp_p_q.pop_front()));
      end
      if (snk_valid && snk_ready) begin
        last_snk = cyc;
        if (exp_s_q.size() == 0) fail_note("snk_extra", 64'(snk_data));
        else check("snk_data", 64'(snk_data), 64'(exp_s_q.pop_front()));
      end
      if (set_info) begin
        set_cnt++;
        check("cfg_at_set", 64'({config_q, config_p, config_U, config_S, config_F, config_W}),
              64'(exp_cfg));
      end
      if (dbg_state == ST_DRAIN) drain_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", 64'(busy), 64'd1);
        check("cfg_at_done", 64'({config_q, config_p, config_U, config_S, config_F, config_W}),
              64'(exp_cfg));
      end
      if (dbg_state != last_state) begin
        if (dbg_state != ST_IDLE) seq = (seq << 3) | int'(dbg_state);
        last_state = dbg_state;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic flush_all();
    exp_f_q.delete(); exp_i_q.delete(); exp_p_q.delete(); exp_s_q.delete();
    src_f.delete(); src_i.delete(); src_p.delete(); op_l.delete();
  endtask

  task automatic setup_job(input logic [38:0] cfg, input int nf, input int ni, input int np,
                           input int nop, input int offer, input int mode,
                           input int unsigned stall, input logic [7:0] b);
    logic [SW-1:0] w;
    logic [7:0] i8;
    @(negedge clk);
    #1;
    flush_all();
    {cfg_q, cfg_p, cfg_U, cfg_S, cfg_F, cfg_W} = cfg;
    exp_cfg = cfg;
    n_filter = CB'(nf); n_ifmap = CB'(ni); n_ipsum = CB'(np); n_opsum = CB'(nop);
    stall_pct = stall;
    op_mode = mode;
    set_cnt = 0; done_cnt = 0; drain_cnt = 0; fen_cnt = 0; pen_cnt = 0; fbeat_cnt = 0;
    last_src = 0; last_snk = 0; done_cyc = 0; seq = 0;
    for (int i = 0; i < nf; i++) begin
      i8 = 8'(i);
      w = {8'hF0, b, i8, b + i8};
      src_f.push_back(w);
      exp_f_q.push_back(w);
    end
    for (int i = 0; i < ni; i++) begin
      i8 = 8'(i);
      w = {8'h11, 8'h22, 8'h33, b + i8 + 8'h40};
      src_i.push_back(w);
      exp_i_q.push_back(w[7:0]);
    end
    for (int i = 0; i < np; i++) begin
      i8 = 8'(i);
      w = {8'h44, 8'h55, 8'h66, b + i8 + 8'h80};
      src_p.push_back(w);
      exp_p_q.push_back(w[7:0]);
    end
    for (int i = 0; i < offer; i++) begin
      i8 = 8'(i);
      op_l.push_back(b + i8 + 8'hC0);
      if (i < nop) exp_s_q.push_back(b + i8 + 8'hC0);
    end
  endtask

  // Start pulse; inputs are scrambled afterwards so only latched values may be used.
  task automatic pulse_start(input logic poke_busy);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    cfg_q = ~cfg_q; cfg_p = ~cfg_p; cfg_U = ~cfg_U; cfg_S = ~cfg_S; cfg_F = ~cfg_F; cfg_W = ~cfg_W;
    n_filter = 16'd7; n_ifmap = 16'd7; n_ipsum = 16'd7; n_opsum = 16'd7;
    if (poke_busy) begin
      repeat (2) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done_cnt == 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (done_cnt == 0) fail_note("done_timeout", 64'(c));
    repeat (4) @(posedge clk);
  endtask

  task automatic end_checks(input string tag, input int nf, input int ni, input int np);
    check({tag, "_f_left"}, 64'(exp_f_q.size()), 64'd0);
    check({tag, "_i_left"}, 64'(exp_i_q.size()), 64'd0);
    check({tag, "_p_left"}, 64'(exp_p_q.size()), 64'd0);
    check({tag, "_s_left"}, 64'(exp_s_q.size()), 64'd0);
    check({tag, "_set_info_cycles"}, 64'(set_cnt), 64'd1);
    check({tag, "_done_cycles"}, 64'(done_cnt), 64'd1);
    check({tag, "_state_seq"}, 64'(seq), 64'(exp_seq(nf, ni, np)));
    check({tag, "_idle_after"}, 64'({busy, dbg_state}), 64'({1'b0, ST_IDLE}));
    if (nf == 0) check({tag, "_filter_en_cycles"}, 64'(fen_cnt), 64'd0);
    if (np == 0) check({tag, "_ipsum_en_cycles"}, 64'(pen_cnt), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flags", 64'({busy, done, set_info, src_ready, snk_valid, opsum_ready,
                            filter_enable, ifmap_enable, ipsum_enable}), 64'd0);
    check("rst_src_sel", 64'(src_sel), 64'd3);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_config", 64'({config_q, config_p, config_U, config_S, config_F, config_W}), 64'd0);
    @(posedge clk); #2 rst = 1'b1;

    // Reset in the middle of the filter phase.
    setup_job({2'd2, 5'd9, 4'd1, 4'd2, 12'h0AB, 12'h0CD}, 4, 2, 1, 1, 1, 0, 0, 8'h10);
    pulse_start(1'b0);
    for (int c = 0; c < 30 && fbeat_cnt < 1; c++) @(posedge clk);
    check("t1_reached_filter", 64'(fbeat_cnt >= 1), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("t1_rst_flags", 64'({busy, done, set_info, src_ready, snk_valid, opsum_ready,
                               filter_enable, ifmap_enable, ipsum_enable}), 64'd0);
    check("t1_rst_src_sel", 64'(src_sel), 64'd3);
    check("t1_rst_counts", 64'({dbg_state, dbg_in_count, dbg_op_count}), 64'(ST_IDLE));
    check("t1_rst_config", 64'({config_q, config_p, config_U, config_S, config_F, config_W}), 64'd0);
    flush_all();
    @(negedge clk);
    check("t1_rst_hold", 64'({busy, done, src_ready, filter_enable}), 64'd0);
    @(posedge clk); #2 rst = 1'b1;

    // Job 2: always ready, opsum held back until all inputs are delivered.
    setup_job({2'd1, 5'd4, 4'd2, 4'd3, 12'h00A, 12'h014}, 3, 5, 2, 2, 2, 1, 0, 8'h20);
    pulse_start(1'b0);
    wait_done(300);
    end_checks("t2", 3, 5, 2);
    check("t2_done_after_last_opsum", 64'(done_cyc - last_snk), 64'd2);

    // Job 2 again with 50% stalls on every handshake.
    setup_job({2'd1, 5'd4, 4'd2, 4'd3, 12'h00A, 12'h014}, 3, 5, 2, 2, 2, 0, 50, 8'h30);
    pulse_start(1'b0);
    wait_done(600);
    end_checks("t3", 3, 5, 2);

    // Zero-count filter and ipsum phases are skipped.
    setup_job({2'd3, 5'd31, 4'd15, 4'd1, 12'hFFF, 12'h001}, 0, 3, 0, 1, 1, 0, 0, 8'h40);
    pulse_start(1'b0);
    wait_done(300);
    end_checks("t4", 0, 3, 0);

    // PE offers 4 opsum beats, only 2 may be accepted.
    setup_job({2'd0, 5'd1, 4'd4, 4'd5, 12'h123, 12'h456}, 1, 1, 1, 2, 4, 0, 0, 8'h50);
    pulse_start(1'b0);
    wait_done(300);
    end_checks("t5", 1, 1, 1);
    check("t5_opsum_left", 64'(op_l.size()), 64'd2);

    // start while busy, final input beat coincident with final opsum beat.
    setup_job({2'd2, 5'd17, 4'd6, 4'd7, 12'h789, 12'hABC}, 2, 1, 2, 2, 2, 2, 0, 8'h60);
    pulse_start(1'b1);
    wait_done(300);
    end_checks("t6", 2, 1, 2);
    check("t6_coincident", 64'(last_snk), 64'(last_src));
    check("t6_drain_cycles", 64'(drain_cnt), 64'd1);
    check("t6_done_latency", 64'(done_cyc - last_src), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
